exception_sequencer: RTL
========================

Name: exception_sequencer

Overview:
Multicycle sequencer that takes the MIPS datapath from the faulting instruction to its handler. On an exception it saves EPC, records the cause, reads the handler address from a memory vector table, and loads it into PC. It also returns from a handler (ERET) by reloading PC from EPC. It sits beside the main control unit: it overrides the memory address mux and the PC source while it is busy, and the control unit holds off while exc_busy is high.

Parameters:
VEC_BASE, 32'd240, word-aligned byte address of the vector table (3 words: opcode, overflow, div-by-zero)
MEM_LAT, 2, cycles the memory address is held before read data is sampled (legal range 1 to 15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
exc_en  in  1  control unit's check window; requests are sampled only when this is high
req_opcode  in  1  invalid opcode detected
req_ovf  in  1  ALU overflow
req_divz  in  1  divide by zero
eret_req  in  1  ERET decoded
pc_in  in  32  current PC register value
mem_data  in  32  memory read data
exc_busy  out  1  sequencer owns memory address and PC; control unit must stall
exc_mem_sel  out  1  1 = memory address taken from exc_mem_addr
exc_mem_addr  out  32  vector table address
exc_pc_write  out  1  one-cycle PC load strobe
exc_pc_value  out  32  value to load into PC
epc  out  32  exception PC register
cause  out  32  cause register
exc_done  out  1  one-cycle pulse when the handler PC is loaded
double_fault  out  1  sticky; set when a request arrives while busy

Behaviour:
- Reset: state IDLE; every output 0, including epc, cause, double_fault and the latency counter. Reset mid-sequence aborts with no PC write.
- States: IDLE, SAVE, ADDR, LOAD, ERET.
- IDLE, exc_en=1 and any req_* high: go to SAVE.
  - Priority: opcode > ovf > divz.
  - Latch the code: cause = 1 (opcode), 2 (ovf) or 3 (divz).
  - Latch the vector index: 0, 1 or 2 respectively.
- IDLE, exc_en=1, no req_*, eret_req=1: go to ERET. An exception wins over ERET in the same cycle.
- exc_en=0: all requests are ignored with no side effects.
- SAVE (1 cycle): epc <= pc_in - 4, modulo 2^32 (pc_in=0 gives 32'hFFFFFFFC). Load the counter with MEM_LAT-1. Go to ADDR.
- ADDR (MEM_LAT cycles):
  - exc_mem_sel=1.
  - exc_mem_addr = VEC_BASE + 4*index, held constant.
  - Counter decrements each cycle; leave for LOAD when it is 0.
- LOAD (1 cycle):
  - exc_pc_write=1, exc_pc_value=mem_data, exc_done=1.
  - exc_mem_sel stays 1 so the address stays stable.
  - Next state IDLE.
- ERET (1 cycle): exc_pc_write=1, exc_pc_value=epc. Next state IDLE. epc and cause are unchanged.
- exc_busy = 1 in SAVE, ADDR, LOAD and ERET; 0 in IDLE. It is a registered, state-decoded output.
- exc_pc_write and exc_done are high in exactly one cycle per sequence.
- exc_mem_sel is 0 outside ADDR and LOAD.
- Latency: request sampled in cycle T.
  - SAVE at T+1, ADDR from T+2 to T+1+MEM_LAT, LOAD at T+2+MEM_LAT.
  - With MEM_LAT=2, the PC write happens at T+4.
- Any req_* high while busy (exc_en ignored): the request is dropped, double_fault is set, and the current sequence completes unchanged. double_fault is cleared only by reset.
- eret_req while busy is ignored, with no flag set.
- Back-to-back: a request in the IDLE cycle right after LOAD is accepted normally.

Decomposition:
- Package mips_exc_pkg holds:
  - state enum (IDLE, SAVE, ADDR, LOAD, ERET);
  - cause code constants CAUSE_OPCODE=1, CAUSE_OVF=2, CAUSE_DIVZ=3;
  - vector index constants.
- Single module, no sub-module. The latency counter is 4 bits, inline.

Test Plan:
1. Reset, then req_ovf=1 with exc_en=1, pc_in=32'h00000044, mem_data=32'h00000400 during ADDR, MEM_LAT=2 -> epc=32'h40, cause=2, exc_mem_addr=244 for 2 cycles, exc_pc_write with value 32'h400 at T+4, exc_done pulses once.
2. req_opcode, req_ovf and req_divz all high together, pc_in=8 -> cause=1, exc_mem_addr=240, epc=4.
3. req_divz with pc_in=0 -> epc=32'hFFFFFFFC, cause=3, exc_mem_addr=248.
4. req_ovf while in ADDR -> double_fault=1 and stays 1; cause and epc unchanged; handler load completes on schedule.
5. After an exception with epc=32'h40: eret_req with exc_en=1 -> one cycle later exc_pc_write=1, exc_pc_value=32'h40, exc_busy high for 1 cycle. Same cycle with req_ovf high -> the exception is taken instead.
6. reset asserted in ADDR -> next cycle all outputs 0, no exc_pc_write; req_* with exc_en=0 -> no response.

Source files
------------

// File: rtl/exception_sequencer_pkg.sv
// Shared types and constants for the MIPS exception sequencer.
// Holds the FSM encoding, cause codes, vector indices and the vector-address helper.
package mips_exc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    ADDR,
    LOAD,
    ERET
  } exc_state_t;

  localparam logic [31:0] CAUSE_OPCODE = 32'd1;
  localparam logic [31:0] CAUSE_OVF    = 32'd2;
  localparam logic [31:0] CAUSE_DIVZ   = 32'd3;

  localparam logic [1:0] VEC_IDX_OPCODE = 2'd0;
  localparam logic [1:0] VEC_IDX_OVF    = 2'd1;
  localparam logic [1:0] VEC_IDX_DIVZ   = 2'd2;

  // Vector table entries are consecutive 32-bit words.
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [1:0] idx);
    return base + {28'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Bundle between the exception sequencer (master) and the control unit / datapath (slave).
// Carries request lines, PC/memory inputs and the override/status outputs.
interface exception_sequencer_if;

  logic        exc_en;
  logic        req_opcode;
  logic        req_ovf;
  logic        req_divz;
  logic        eret_req;
  logic [31:0] pc_in;
  logic [31:0] mem_data;

  logic        exc_busy;
  logic        exc_mem_sel;
  logic [31:0] exc_mem_addr;
  logic        exc_pc_write;
  logic [31:0] exc_pc_value;
  logic [31:0] epc;
  logic [31:0] cause;
  logic        exc_done;
  logic        double_fault;

  modport master (
    input  exc_en, req_opcode, req_ovf, req_divz, eret_req, pc_in, mem_data,
    output exc_busy, exc_mem_sel, exc_mem_addr, exc_pc_write, exc_pc_value,
    output epc, cause, exc_done, double_fault
  );

  modport slave (
    output exc_en, req_opcode, req_ovf, req_divz, eret_req, pc_in, mem_data,
    input  exc_busy, exc_mem_sel, exc_mem_addr, exc_pc_write, exc_pc_value,
    input  epc, cause, exc_done, double_fault
  );

endinterface

// File: rtl/exception_sequencer.sv
// Exception sequencer: saves EPC/cause, fetches the handler vector and loads PC; also performs ERET.
// Latency: request in cycle T -> PC load at T+2+MEM_LAT (exception) or T+1 (ERET).
// Backpressure: none accepted; control unit stalls on exc_busy, requests while busy are dropped and flagged.
module exception_sequencer
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'd240,
  parameter int          MEM_LAT  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  exception_sequencer_if.master bus
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  exc_state_t  state;
  exc_state_t  state_nxt;
  logic [3:0]  lat_cnt;
  logic [1:0]  vec_idx;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic        dfault_q;

  logic any_req;
  logic take_exc;
  logic take_eret;

  assign any_req   = bus.req_opcode | bus.req_ovf | bus.req_divz;
  assign take_exc  = bus.exc_en & any_req;
  assign take_eret = bus.exc_en & ~any_req & bus.eret_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take_exc) begin
          state_nxt = SAVE;
        end else if (take_eret) begin
          state_nxt = ERET;
        end
      end
      SAVE:    state_nxt = ADDR;
      ADDR:    if (lat_cnt == 4'd0) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      ERET:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lat_cnt  <= 4'd0;
      vec_idx  <= 2'd0;
      epc_q    <= 32'd0;
      cause_q  <= 32'd0;
      dfault_q <= 1'b0;
    end else begin
      if (state == IDLE && take_exc) begin
        if (bus.req_opcode) begin
          cause_q <= CAUSE_OPCODE;
          vec_idx <= VEC_IDX_OPCODE;
        end else if (bus.req_ovf) begin
          cause_q <= CAUSE_OVF;
          vec_idx <= VEC_IDX_OVF;
        end else begin
          cause_q <= CAUSE_DIVZ;
          vec_idx <= VEC_IDX_DIVZ;
        end
      end
      // PC already points past the faulting instruction; wrap is intentional.
      if (state == SAVE) begin
        epc_q   <= bus.pc_in - 32'd4;
        lat_cnt <= LAT_INIT;
      end
      if (state == ADDR && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (state != IDLE && any_req) begin
        dfault_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.exc_busy     = 1'b0;
    bus.exc_mem_sel  = 1'b0;
    bus.exc_mem_addr = 32'd0;
    bus.exc_pc_write = 1'b0;
    bus.exc_pc_value = 32'd0;
    bus.exc_done     = 1'b0;
    case (state)
      SAVE: begin
        bus.exc_busy = 1'b1;
      end
      ADDR: begin
        bus.exc_busy     = 1'b1;
        bus.exc_mem_sel  = 1'b1;
        bus.exc_mem_addr = vec_addr(VEC_BASE, vec_idx);
      end
      LOAD: begin
        // Address held through LOAD so the memory output stays valid while sampled.
        bus.exc_busy     = 1'b1;
        bus.exc_mem_sel  = 1'b1;
        bus.exc_mem_addr = vec_addr(VEC_BASE, vec_idx);
        bus.exc_pc_write = 1'b1;
        bus.exc_pc_value = bus.mem_data;
        bus.exc_done     = 1'b1;
      end
      ERET: begin
        bus.exc_busy     = 1'b1;
        bus.exc_pc_write = 1'b1;
        bus.exc_pc_value = epc_q;
      end
      default: ;
    endcase
  end

  assign bus.epc          = epc_q;
  assign bus.cause        = cause_q;
  assign bus.double_fault = dfault_q;

endmodule
